// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache word fetches and dcache 2-word
// block transfers. dcache has priority, but icache is guaranteed a grant
// after STARVE_MAX consecutive dcache blocks while it is waiting.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [63:0] dstore,
  output logic        dwait,
  output logic [63:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, ISERV, DSERV0, DSERV1} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] starve_cnt, starve_n;
  logic [31:0]      word0, word0_n;
  logic             mem_err_n;
  logic             done, err_done, d_req;
  logic [28:0]      blk_base;

  // Block offset and byte offset bits of daddr are replaced by the word index.
  logic unused_daddr;
  assign unused_daddr = ^daddr[2:0];

  assign done     = (ramstate_t'(ramstate) == RS_ACCESS) || (ramstate_t'(ramstate) == RS_ERROR);
  assign err_done = (ramstate_t'(ramstate) == RS_ERROR);
  assign d_req    = dREN | dWEN;
  assign blk_base = daddr[31:3];

  // State, starvation counter, first-word latch and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      word0      <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      word0      <= word0_n;
      mem_err    <= mem_err_n;
    end
  end

  // Grant arbitration, service progress and abort handling.
  always_comb begin
    state_n   = state;
    starve_n  = starve_cnt;
    word0_n   = word0;
    mem_err_n = mem_err;
    case (state)
      IDLE: begin
        if (d_req && (!iREN || (starve_cnt < CNT_W'(STARVE_MAX)))) begin
          state_n = DSERV0;
        end else if (iREN) begin
          state_n = ISERV;
        end
      end
      ISERV: begin
        if (!iREN) begin
          state_n = IDLE;
        end else if (done) begin
          state_n   = IDLE;
          starve_n  = '0;
          mem_err_n = mem_err | err_done;
        end
      end
      DSERV0: begin
        if (!d_req) begin
          state_n = IDLE;
        end else if (done) begin
          state_n   = DSERV1;
          word0_n   = ramload;
          mem_err_n = mem_err | err_done;
        end
      end
      DSERV1: begin
        if (!d_req) begin
          state_n = IDLE;
        end else if (done) begin
          state_n   = IDLE;
          mem_err_n = mem_err | err_done;
          if (!iREN) begin
            starve_n = '0;
          end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_n = starve_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port and cache-side responses, decoded from the current grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state)
      ISERV: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = ramload;
      end
      DSERV0: begin
        ramWEN   = dWEN;
        ramREN   = ~dWEN;
        ramaddr  = {blk_base, 1'b0, 2'b00};
        ramstore = dstore[31:0];
      end
      DSERV1: begin
        ramWEN   = dWEN;
        ramREN   = ~dWEN;
        ramaddr  = {blk_base, 1'b1, 2'b00};
        ramstore = dstore[63:32];
        dload    = {ramload, word0};
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~((state == ISERV) & done);
  assign dwait = d_req & ~((state == DSERV1) & done);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a response scoreboard.
module tb_cache_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, RST;
  logic        iREN, iwait;
  logic [31:0] iaddr, iload;
  logic        dREN, dWEN, dwait;
  logic [31:0] daddr;
  logic [63:0] dstore, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_i[$];
  logic [63:0] exp_d[$];
  logic [64:0] exp_r[$];
  bit          ram_chk = 0;
  logic [9:0]  seq;
  int          n_done;

  cache_mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  // Scoreboard: pop expected responses as the DUT completes them.
  always @(negedge CLK) begin
    if (!RST) begin
      if (iREN && !iwait) begin
        if (exp_i.size() > 0) chk("iload", 65'(iload), 65'(exp_i.pop_front()));
        else chk("iload_unexpected", 65'(exp_i.size()), 65'd1);
      end
      if (dREN && !dWEN && !dwait) begin
        if (exp_d.size() > 0) chk("dload", 65'(dload), 65'(exp_d.pop_front()));
        else chk("dload_unexpected", 65'(exp_d.size()), 65'd1);
      end
      if (ram_chk && (ramREN || ramWEN) && (ramstate == ACCESS || ramstate == ERROR)) begin
        if (exp_r.size() > 0)
          chk("ram_access", {ramWEN, ramaddr, (ramWEN ? ramstore : 32'h0)}, exp_r.pop_front());
        else chk("ram_unexpected", 65'(exp_r.size()), 65'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #1 RST = 1'b1;
    #1;
    chk("rst_ramREN", 65'(ramREN), 65'd0);
    chk("rst_ramWEN", 65'(ramWEN), 65'd0);
    chk("rst_ramaddr", 65'(ramaddr), 65'd0);
    chk("rst_ramstore", 65'(ramstore), 65'd0);
    chk("rst_mem_err", 65'(mem_err), 65'd0);
    chk("rst_iwait", 65'(iwait), 65'd1);
    chk("rst_dwait", 65'(dwait), 65'd0);
    iREN = 1'b0;
    @(posedge CLK);
    nxt();
    RST = 1'b0;

    // 1) icache fetch with two BUSY cycles
    iREN = 1'b1; iaddr = 32'h40; ram_chk = 1;
    exp_i.push_back(32'hDEADBEEF);
    exp_r.push_back({1'b0, 32'h40, 32'h0});
    neg(); chk("t1_c0_ramREN", 65'(ramREN), 65'd0); chk("t1_c0_iwait", 65'(iwait), 65'd1);
    nxt(); ramstate = BUSY;
    neg(); chk("t1_c1_ramREN", 65'(ramREN), 65'd1); chk("t1_c1_ramaddr", 65'(ramaddr), 65'h40);
    nxt();
    neg(); chk("t1_c2_ramREN", 65'(ramREN), 65'd1); chk("t1_c2_iwait", 65'(iwait), 65'd1);
    nxt(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    neg(); chk("t1_c3_ramREN", 65'(ramREN), 65'd1); chk("t1_c3_iwait", 65'(iwait), 65'd0);
    nxt(); iREN = 1'b0; ramstate = FREE;
    neg(); chk("t1_c4_ramREN", 65'(ramREN), 65'd0);

    // 2) zero-wait dcache block read
    nxt(); dREN = 1'b1; daddr = 32'h104; ramstate = ACCESS; ramload = '0;
    exp_d.push_back(64'h00000022_00000011);
    exp_r.push_back({1'b0, 32'h100, 32'h0});
    exp_r.push_back({1'b0, 32'h104, 32'h0});
    neg(); chk("t2_c0_dwait", 65'(dwait), 65'd1);
    nxt(); ramload = 32'h11;
    neg(); chk("t2_c1_ramaddr", 65'(ramaddr), 65'h100); chk("t2_c1_dwait", 65'(dwait), 65'd1);
    nxt(); ramload = 32'h22;
    neg(); chk("t2_c2_ramaddr", 65'(ramaddr), 65'h104); chk("t2_c2_dwait", 65'(dwait), 65'd0);
    nxt(); dREN = 1'b0; ramstate = FREE;
    neg(); chk("t2_c3_ramREN", 65'(ramREN), 65'd0);

    // 3) dcache writeback wins over a simultaneous icache fetch
    nxt(); dWEN = 1'b1; daddr = 32'h100; dstore = {32'hB, 32'hA};
    iREN = 1'b1; iaddr = 32'h200; ramstate = ACCESS; ramload = 32'h77;
    exp_r.push_back({1'b1, 32'h100, 32'hA});
    exp_r.push_back({1'b1, 32'h104, 32'hB});
    exp_r.push_back({1'b0, 32'h200, 32'h0});
    exp_i.push_back(32'h77);
    neg(); chk("t3_c0_ramWEN", 65'(ramWEN), 65'd0);
    nxt();
    neg(); chk("t3_c1_ramWEN", 65'(ramWEN), 65'd1); chk("t3_c1_ramstore", 65'(ramstore), 65'hA);
    nxt();
    neg(); chk("t3_c2_dwait", 65'(dwait), 65'd0); chk("t3_c2_ramaddr", 65'(ramaddr), 65'h104);
    nxt(); dWEN = 1'b0;
    neg(); chk("t3_c3_bubble", 65'({ramREN, ramWEN}), 65'd0); chk("t3_c3_iwait", 65'(iwait), 65'd1);
    nxt();
    neg(); chk("t3_c4_ramaddr", 65'(ramaddr), 65'h200); chk("t3_c4_iwait", 65'(iwait), 65'd0);
    nxt(); iREN = 1'b0; ram_chk = 0; ramstate = FREE;

    // 4) bounded starvation: 4 dcache blocks, 1 icache word, repeat
    nxt(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600;
    ramstate = ACCESS; ramload = 32'h55;
    for (int k = 0; k < 8; k++) exp_d.push_back(64'h00000055_00000055);
    for (int k = 0; k < 2; k++) exp_i.push_back(32'h55);
    seq = '0; n_done = 0;
    for (int c = 0; c < 28; c++) begin
      neg();
      if (iREN && !iwait) begin
        seq = {seq[8:0], 1'b1}; n_done++;
      end else if (dREN && !dwait) begin
        seq = {seq[8:0], 1'b0}; n_done++;
      end
      nxt();
    end
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    chk("t4_order", 65'(seq), 65'(10'b0000100001));
    chk("t4_count", 65'(n_done), 65'd10);

    // 5) ERROR completion on word 0 is sticky
    nxt(); dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
    exp_d.push_back(64'h00000002_00000001);
    neg(); chk("t5_c0_mem_err", 65'(mem_err), 65'd0);
    nxt(); ramstate = ERROR; ramload = 32'h1;
    neg(); chk("t5_c1_mem_err", 65'(mem_err), 65'd0);
    nxt(); ramstate = ACCESS; ramload = 32'h2;
    neg(); chk("t5_c2_mem_err", 65'(mem_err), 65'd1); chk("t5_c2_dwait", 65'(dwait), 65'd0);
    nxt(); dREN = 1'b0; ramstate = FREE;
    nxt();
    neg(); chk("t5_sticky", 65'(mem_err), 65'd1);

    // 6) async reset in the second word, block restarts from word 0
    nxt(); dREN = 1'b1; daddr = 32'h404; ramstate = ACCESS; ramload = 32'h9;
    neg();
    nxt();
    neg();
    nxt(); ramstate = BUSY;
    neg(); chk("t6_c2_ramREN", 65'(ramREN), 65'd1); chk("t6_c2_ramaddr", 65'(ramaddr), 65'h404);
    #1 RST = 1'b1;
    #1;
    chk("t6_rst_ramREN", 65'(ramREN), 65'd0);
    chk("t6_rst_ramaddr", 65'(ramaddr), 65'd0);
    chk("t6_rst_dwait", 65'(dwait), 65'd1);
    chk("t6_rst_mem_err", 65'(mem_err), 65'd0);
    nxt(); RST = 1'b0; ramstate = ACCESS; ramload = 32'hA;
    exp_d.push_back(64'h0000000B_0000000A);
    neg(); chk("t6_c3_ramREN", 65'(ramREN), 65'd0);
    nxt();
    neg(); chk("t6_c4_ramaddr", 65'(ramaddr), 65'h400); chk("t6_c4_ramREN", 65'(ramREN), 65'd1);
    nxt(); ramload = 32'hB;
    neg(); chk("t6_c5_dwait", 65'(dwait), 65'd0);
    nxt(); dREN = 1'b0; ramstate = FREE;

    // 7) icache drops its request mid-service
    nxt(); iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    neg();
    nxt();
    neg(); chk("t7_c1_ramREN", 65'(ramREN), 65'd1);
    nxt(); iREN = 1'b0;
    neg(); chk("t7_c2_ramREN", 65'(ramREN), 65'd1);
    nxt();
    neg(); chk("t7_c3_ramREN", 65'(ramREN), 65'd0);
    nxt(); ramstate = FREE;

    chk("end_exp_i_left", 65'(exp_i.size()), 65'd0);
    chk("end_exp_d_left", 65'(exp_d.size()), 65'd0);
    chk("end_exp_r_left", 65'(exp_r.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
